// File: rtl/instr_loader.sv
// Streams a host program into instruction memory, pulses St to launch the processor,
// then counts run cycles until done and parks in HALT until restart.
module instr_loader #(
   parameter int ADDR_BIT = 8,
   parameter int DATA_BIT = 32
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                in_valid,
   input  logic [DATA_BIT-1:0] in_data,
   input  logic                in_last,
   output logic                in_ready,
   output logic                mem_we,
   output logic [ADDR_BIT-1:0] mem_addr,
   output logic [DATA_BIT-1:0] mem_wdata,
   output logic                St,
   input  logic                done,
   input  logic                restart,
   output logic                halted,
   output logic                err,
   output logic [ADDR_BIT-1:0] word_count,
   output logic [31:0]         run_cycles
);

   localparam logic [2:0] S_LOAD  = 3'd0;
   localparam logic [2:0] S_DRAIN = 3'd1;
   localparam logic [2:0] S_START = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_HALT  = 3'd4;

   // Highest word-aligned address; a non-final word landing here ends the program.
   localparam logic [ADDR_BIT-1:0] LAST_ADDR = {ADDR_BIT{1'b1}} << 2;

   logic [2:0]          state;
   logic [ADDR_BIT-1:0] wr_ptr;
   logic                accept;
   logic                at_end;

   assign in_ready = (state == S_LOAD) && !RST;
   assign accept   = in_valid && in_ready;
   assign at_end   = (wr_ptr == LAST_ADDR);
   assign St       = (state == S_START);
   assign halted   = (state == S_HALT);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= S_LOAD;
         wr_ptr     <= '0;
         word_count <= '0;
         run_cycles <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         err        <= 1'b0;
      end else begin
         mem_we <= accept;
         case (state)
            S_LOAD: begin
               if (accept) begin
                  mem_addr   <= wr_ptr;
                  mem_wdata  <= in_data;
                  word_count <= word_count + ADDR_BIT'(1);
                  // Pointer is left in place at the top so it never wraps to 0.
                  if (!at_end)
                     wr_ptr <= wr_ptr + ADDR_BIT'(4);
                  if (in_last || at_end)
                     state <= S_DRAIN;
                  if (!in_last && at_end)
                     err <= 1'b1;
               end
            end
            S_DRAIN: state <= S_START;
            S_START: state <= S_RUN;
            S_RUN: begin
               if (run_cycles != 32'hFFFF_FFFF)
                  run_cycles <= run_cycles + 32'd1;
               if (done)
                  state <= S_HALT;
            end
            S_HALT: begin
               if (restart) begin
                  state      <= S_LOAD;
                  wr_ptr     <= '0;
                  word_count <= '0;
                  run_cycles <= '0;
                  err        <= 1'b0;
               end
            end
            default: state <= S_LOAD;
         endcase
      end
   end

endmodule
